shift_arbiter: RTL

//  Shares one 16-bit shift/rotate datapath (ror_core) between NUM_REQ requesters.

---
 rtl/shift_pkg.sv | 14 +
 rtl/ror_core.sv | 37 +++
 rtl/shift_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter and its datapath.
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRA = 2'b01,
    SH_ROR = 2'b10,
    SH_RSV = 2'b11
  } shift_op_t;

endpackage

// File: rtl/ror_core.sv
// Combinational 16-bit log shifter: four stages of 1/2/4/8 bits.
// SLL zero-fills, SRA replicates bit 15, ROR rotates right, RSV passes through.
module ror_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [AMT_W-1:0]  amt,
  input  shift_op_t         op,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] stage [AMT_W+1];

  assign stage[0] = in;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int Sh = 1 << k;
    logic [DATA_W-1:0] shifted;

    // Shift the previous stage's value by 2^k in the direction the op asks for.
    always_comb begin
      shifted = stage[k];
      case (op)
        SH_SLL:  shifted = stage[k] << Sh;
        SH_SRA:  shifted = $signed(stage[k]) >>> Sh;
        SH_ROR:  shifted = (stage[k] >> Sh) | (stage[k] << (DATA_W - Sh));
        SH_RSV:  shifted = stage[k];
        default: shifted = stage[k];
      endcase
    end

    assign stage[k+1] = amt[k] ? shifted : stage[k];
  end

  assign out = stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one ror_core between NUM_REQ requesters.
// One accept per cycle; result and owner ID are registered and drained valid/ready.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               any_valid;
  logic               load;
  logic [DATA_W-1:0]  sel_data;
  logic [AMT_W-1:0]   sel_amt;
  shift_op_t          sel_op;
  logic [DATA_W-1:0]  shift_out;

  // Slot is free, or the held result leaves this cycle.
  assign load = ~rsp_valid | rsp_ready;

  // First valid requester scanning upward from rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    grant[grant_idx] = any_valid;
  end

  // Held low during reset so no requester believes it was accepted into a discarded slot.
  assign req_ready = grant & {NUM_REQ{load & ~rst}};

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Route the granted requester's operands into the shared shifter.
  always_comb begin
    sel_data = req_data[DATA_W*int'(grant_idx) +: DATA_W];
    sel_amt  = req_amt[AMT_W*int'(grant_idx) +: AMT_W];
    sel_op   = shift_op_t'(req_op[2*int'(grant_idx) +: 2]);
  end

  ror_core u_ror_core (
    .in  (sel_data),
    .amt (sel_amt),
    .op  (sel_op),
    .out (shift_out)
  );

  // Result register: capture on load with a grant, empty on drain without one, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      rsp_valid <= any_valid;
      if (any_valid) begin
        rsp_data <= shift_out;
        rsp_id   <= grant_idx;
        rr_ptr   <= ptr_next;
      end
    end
  end

endmodule
